// File: rtl/vstore_sequencer_if.sv
// vstore_sequencer_if: request, completion and write-port bundle
// shared by the vector store sequencer and its requester.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 14
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

interface vstore_sequencer_if #(
  parameter int NBANKS = 4,
  parameter int VLEN   = 128,
  parameter int ADDR_W = `DATAMEM_BITS,
  parameter int BANK_W = `DATAMEM_WIDTH
);
  localparam int DATA_W    = 4 * VLEN;
  localparam int MAX_ELEMS = DATA_W / 8;
  localparam int BE_W      = BANK_W / 8;

  logic                     start;
  logic                     ready;
  logic [3:0]               store_op;
  logic [2:0]               lmul;
  logic [ADDR_W-1:0]        stride;
  logic [ADDR_W-1:0]        address;
  logic [DATA_W-1:0]        data;
  logic                     vm;
  logic [MAX_ELEMS-1:0]     mask;
  logic [NBANKS*ADDR_W-1:0] mem_addr;
  logic [NBANKS*BANK_W-1:0] mem_data;
  logic [NBANKS*BE_W-1:0]   mem_be;
  logic [NBANKS-1:0]        mem_valid;
  logic                     mem_ready;
  logic                     done;
  logic                     err;

  modport slave (
    input  start, store_op, lmul, stride, address,
    input  data, vm, mask, mem_ready,
    output ready, mem_addr, mem_data, mem_be,
    output mem_valid, done, err
  );

  modport master (
    output start, store_op, lmul, stride, address,
    output data, vm, mask, mem_ready,
    input  ready, mem_addr, mem_data, mem_be,
    input  mem_valid, done, err
  );
endinterface

// File: rtl/vstore_sequencer.sv
// vstore_sequencer: splits a captured vector register group into
// NBANKS-wide write beats for unit-stride and strided stores.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 14
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module vstore_sequencer #(
  parameter int NBANKS = 4,
  parameter int VLEN   = 128,
  parameter int ADDR_W = `DATAMEM_BITS,
  parameter int BANK_W = `DATAMEM_WIDTH
) (
  input logic clk,
  input logic nrst,
  vstore_sequencer_if.slave bus
);
  localparam int DATA_W    = 4 * VLEN;
  localparam int MAX_ELEMS = DATA_W / 8;
  localparam int BE_W      = BANK_W / 8;
  localparam int LOG_NB    = $clog2(NBANKS);
  localparam int IW        = $clog2(MAX_ELEMS) + 2;
  localparam int SW        = IW + 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [2:0]           lmul_q, lmul_d;
  logic [ADDR_W-1:0]    stride_q, stride_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 vm_q, vm_d;
  logic [MAX_ELEMS-1:0] mask_q, mask_d;
  logic [IW-1:0]        beat_q, beat_d;

  logic [1:0]           esh;
  logic                 legal;
  logic [ADDR_W-1:0]    estride;
  logic [3:0]           be_pat;
  logic [IW-1:0]        nelem;
  logic [IW-1:0]        nbeats_m1;
  logic                 issue;
  logic                 last;
  logic                 advance;

  logic [IW-1:0]        idx;
  logic [SW-1:0]        shamt;
  logic [DATA_W-1:0]    dsh;
  logic [MAX_ELEMS-1:0] msh;
  logic [BANK_W-1:0]    elem;
  logic                 en;

  logic [NBANKS*ADDR_W-1:0] maddr;
  logic [NBANKS*BANK_W-1:0] mdata;
  logic [NBANKS*BE_W-1:0]   mbe;
  logic [NBANKS-1:0]        mvalid;

  function automatic logic op_ok(
    input logic [3:0] op,
    input logic [2:0] lm
  );
    return (op >= 4'd7) && (op <= 4'd12) && (lm <= 3'd2);
  endfunction

  // log2 of element width in bytes
  function automatic logic [1:0] eew_sh(input logic [3:0] op);
    logic [1:0] s;
    unique case (1'b1)
      op == 4'd7, op == 4'd10: s = 2'd0;
      op == 4'd8, op == 4'd11: s = 2'd1;
      default:                 s = 2'd2;
    endcase
    return s;
  endfunction

  always_comb begin
    esh     = eew_sh(op_q);
    legal   = op_ok(op_q, lmul_q);
    estride = (op_q >= 4'd10) ? stride_q
                              : ADDR_W'(3'd1 << esh);
    case (esh)
      2'd0:    be_pat = 4'h1;
      2'd1:    be_pat = 4'h3;
      default: be_pat = 4'hF;
    endcase
    nelem     = (IW'(VLEN / 8) << lmul_q[1:0]) >> esh;
    nbeats_m1 = ((nelem + IW'(NBANKS - 1)) >> LOG_NB)
              - IW'(1);
  end

  assign issue = state_q == S_ISSUE;

  // Beat ports are decoded purely from the captured request
  always_comb begin
    maddr  = '0;
    mdata  = '0;
    mbe    = '0;
    mvalid = '0;
    idx    = '0;
    shamt  = '0;
    dsh    = '0;
    msh    = '0;
    elem   = '0;
    en     = 1'b0;
    for (int j = 0; j < NBANKS; j++) begin
      idx   = (beat_q << LOG_NB) + IW'(j);
      msh   = mask_q >> idx;
      en    = issue && (idx < nelem) && (vm_q || msh[0]);
      shamt = SW'({idx, 3'b000}) << esh;
      dsh   = data_q >> shamt;
      case (esh)
        2'd0:    elem = BANK_W'(dsh[7:0]);
        2'd1:    elem = BANK_W'(dsh[15:0]);
        default: elem = BANK_W'(dsh[31:0]);
      endcase
      if (en) begin
        mvalid[j] = 1'b1;
        maddr[j*ADDR_W +: ADDR_W] =
          addr_q + ADDR_W'(idx) * estride;
        mdata[j*BANK_W +: BANK_W] = elem;
        mbe[j*BE_W +: BE_W] = BE_W'(be_pat);
      end
    end
  end

  // Fully masked beats still cost a cycle but never wait
  assign advance = !(|mvalid) || bus.mem_ready;
  assign last    = beat_q == nbeats_m1;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    lmul_d   = lmul_q;
    stride_d = stride_q;
    addr_d   = addr_q;
    data_d   = data_q;
    vm_d     = vm_q;
    mask_d   = mask_q;
    beat_d   = beat_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d     = bus.store_op;
          lmul_d   = bus.lmul;
          stride_d = bus.stride;
          addr_d   = bus.address;
          data_d   = bus.data;
          vm_d     = bus.vm;
          mask_d   = bus.mask;
          beat_d   = '0;
          state_d  = op_ok(bus.store_op, bus.lmul)
                   ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        if (advance) begin
          if (last) state_d = S_DONE;
          else      beat_d  = beat_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      lmul_q   <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      vm_q     <= 1'b0;
      mask_q   <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      lmul_q   <= lmul_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      vm_q     <= vm_d;
      mask_q   <= mask_d;
      beat_q   <= beat_d;
    end
  end

  assign bus.ready     = state_q == S_IDLE;
  assign bus.done      = state_q == S_DONE;
  assign bus.err       = (state_q == S_DONE) && !legal;
  assign bus.mem_addr  = maddr;
  assign bus.mem_data  = mdata;
  assign bus.mem_be    = mbe;
  assign bus.mem_valid = mvalid;
endmodule

// File: tb/tb_vstore_sequencer.sv
// Bench for vstore_sequencer: literal vectors, a request table and
// random requests checked against a per-element store model.
module tb_vstore_sequencer;
  localparam int NB  = 4;
  localparam int VL  = 128;
  localparam int AW  = 14;
  localparam int BW  = 32;
  localparam int DW  = 4 * VL;
  localparam int ME  = DW / 8;
  localparam int BEW = BW / 8;

  typedef struct {
    logic [3:0]    op;
    logic [2:0]    lmul;
    logic [AW-1:0] stride;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          vm;
    logic [ME-1:0] mask;
  } req_t;

  typedef struct {
    req_t r;
    int   mode;
    int   nbeats;
    logic err;
  } vec_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  vstore_sequencer_if #(
    .NBANKS(NB), .VLEN(VL), .ADDR_W(AW), .BANK_W(BW)
  ) bus ();

  vstore_sequencer #(
    .NBANKS(NB), .VLEN(VL), .ADDR_W(AW), .BANK_W(BW)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string         name,
    input logic [DW-1:0] act,
    input logic [DW-1:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int m_eew(input logic [3:0] op);
    case (op)
      4'd7, 4'd10: return 8;
      4'd8, 4'd11: return 16;
      4'd9, 4'd12: return 32;
      default:     return 0;
    endcase
  endfunction

  function automatic logic m_legal(input req_t r);
    return (m_eew(r.op) != 0) && (r.lmul <= 3'd2);
  endfunction

  function automatic int m_nbeats(input req_t r);
    int ne;
    if (!m_legal(r)) return 0;
    ne = VL * (1 << r.lmul) / m_eew(r.op);
    return (ne + NB - 1) / NB;
  endfunction

  task automatic m_beat(
    input  req_t               r,
    input  int                 k,
    output logic [NB*AW-1:0]   a,
    output logic [NB*BW-1:0]   d,
    output logic [NB*BEW-1:0]  b,
    output logic [NB-1:0]      v
  );
    int eew, ne, es, i;
    logic [DW-1:0] t;
    a = '0; d = '0; b = '0; v = '0;
    if (!m_legal(r)) return;
    eew = m_eew(r.op);
    ne  = VL * (1 << r.lmul) / eew;
    es  = (r.op >= 4'd10) ? int'(r.stride) : eew / 8;
    for (int j = 0; j < NB; j++) begin
      i = k * NB + j;
      if (i < ne && (r.vm || r.mask[i])) begin
        v[j] = 1'b1;
        a[j*AW +: AW] = AW'(int'(r.address) + i * es);
        t = r.data >> (i * eew);
        d[j*BW +: BW] = BW'(t) & BW'((64'd1 << eew) - 1);
        b[j*BEW +: BEW] = BEW'((1 << (eew / 8)) - 1);
      end
    end
  endtask

  task automatic drive(input req_t r);
    bus.store_op = r.op;
    bus.lmul     = r.lmul;
    bus.stride   = r.stride;
    bus.address  = r.address;
    bus.data     = r.data;
    bus.vm       = r.vm;
    bus.mask     = r.mask;
  endtask

  task automatic scramble();
    bus.store_op = 4'($urandom);
    bus.lmul     = 3'($urandom);
    bus.stride   = AW'($urandom);
    bus.address  = AW'($urandom);
    for (int w = 0; w < DW / 32; w++)
      bus.data[w*32 +: 32] = $urandom;
    bus.vm   = 1'($urandom);
    bus.mask = {$urandom, $urandom};
  endtask

  // mode: 0 ready=1, 1 toggle, 2 random (+stray start), 3 ready=0 first cycle
  task automatic run_req(
    input  req_t r,
    input  int   mode,
    output int   beats,
    output logic err_seen
  );
    logic [NB*AW-1:0]  ea;
    logic [NB*BW-1:0]  ed;
    logic [NB*BEW-1:0] eb;
    logic [NB-1:0]     ev;
    logic              rdy;
    int                cyc;
    beats = 0;
    cyc   = 0;
    check("ready_idle", bus.ready, 1'b1);
    drive(r);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    while (!bus.done && cyc < 1000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        3:       rdy = (cyc != 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.mem_ready = rdy;
      bus.start = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_beat(r, beats, ea, ed, eb, ev);
      check("beat_valid", bus.mem_valid, ev);
      check("beat_addr", bus.mem_addr, ea);
      check("beat_data", bus.mem_data, ed);
      check("beat_be", bus.mem_be, eb);
      check("busy_ready", bus.ready, 1'b0);
      if (rdy || ev == '0) beats++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 1000) check("done_timeout", bus.done, 1'b1);
    err_seen = bus.err;
    check("done_valid", bus.mem_valid, '0);
    check("done_ready", bus.ready, 1'b0);
    drive(r);
    bus.start     = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("post_done_ready", bus.ready, 1'b1);
    check("post_done_pulse", bus.done, 1'b0);
  endtask

  function automatic vec_t mk(
    input req_t          base,
    input logic [3:0]    op,
    input logic [2:0]    lmul,
    input logic [AW-1:0] stride,
    input logic [AW-1:0] addr,
    input logic          vm,
    input logic [ME-1:0] mask,
    input int            mode,
    input int            nbeats,
    input logic          err
  );
    vec_t v;
    v.r         = base;
    v.r.op      = op;
    v.r.lmul    = lmul;
    v.r.stride  = stride;
    v.r.address = addr;
    v.r.vm      = vm;
    v.r.mask    = mask;
    v.mode      = mode;
    v.nbeats    = nbeats;
    v.err       = err;
    return v;
  endfunction

  initial begin
    req_t base;
    req_t r;
    vec_t tbl[8];
    int   nb;
    logic e;

    base = '{op: 4'd9, lmul: 3'd0, stride: '0, address: '0,
             data: '0, vm: 1'b1, mask: '0};
    for (int w = 0; w < 16; w++)
      base.data[w*32 +: 32] = 32'(w) * 32'h11111111;

    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    scramble();

    #3;
    check("rst_ready", bus.ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_valid", bus.mem_valid, '0);
    check("rst_addr", bus.mem_addr, '0);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // vse32 lmul=1: one full beat
    r = base;
    drive(r);
    bus.start     = 1'b1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    check("r20_addr", bus.mem_addr,
          {14'hC, 14'h8, 14'h4, 14'h0});
    check("r20_data", bus.mem_data,
          {32'h33333333, 32'h22222222, 32'h11111111, 32'h0});
    check("r20_be", bus.mem_be, 16'hFFFF);
    check("r20_valid", bus.mem_valid, 4'hF);
    @(negedge clk);
    check("r20_done", bus.done, 1'b1);
    check("r20_err", bus.err, 1'b0);
    @(negedge clk);
    check("r20_ready", bus.ready, 1'b1);

    // vsse32 lmul=2 stride 8, reset during beat 1
    r        = base;
    r.op     = 4'd12;
    r.lmul   = 3'd1;
    r.stride = 14'd8;
    drive(r);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    check("r21_b0_addr", bus.mem_addr,
          {14'h18, 14'h10, 14'h8, 14'h0});
    @(negedge clk);
    check("r21_b1_addr", bus.mem_addr,
          {14'h38, 14'h30, 14'h28, 14'h20});
    check("r21_b1_data", bus.mem_data,
          {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444});
    #2 nrst = 1'b0;
    #1;
    check("r25_valid", bus.mem_valid, '0);
    check("r25_addr", bus.mem_addr, '0);
    check("r25_data", bus.mem_data, '0);
    check("r25_be", bus.mem_be, '0);
    check("r25_ready", bus.ready, 1'b1);
    check("r25_done", bus.done, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("r25_no_done", bus.done, 1'b0);
      check("r25_idle", bus.ready, 1'b1);
    end

    tbl[0] = mk(base, 4'd9, 3'd0, 14'd0, 14'd0, 1'b1, '0, 0, 1, 1'b0);
    tbl[1] = mk(base, 4'd12, 3'd1, 14'd8, 14'd0, 1'b1, '0, 2, 2, 1'b0);
    tbl[2] = mk(base, 4'd7, 3'd2, 14'd0, 14'h3FF8, 1'b1, '0, 1, 16, 1'b0);
    tbl[3] = mk(base, 4'd8, 3'd0, 14'd0, 14'd0, 1'b0, 64'hF0, 3, 2, 1'b0);
    tbl[4] = mk(base, 4'd3, 3'd0, 14'd0, 14'd0, 1'b1, '0, 0, 0, 1'b1);
    tbl[5] = mk(base, 4'd9, 3'd3, 14'd0, 14'd0, 1'b1, '0, 0, 0, 1'b1);
    tbl[6] = mk(base, 4'd10, 3'd2, 14'h3FFF, 14'h10, 1'b1, '0, 2, 16, 1'b0);
    tbl[7] = mk(base, 4'd13, 3'd1, 14'd4, 14'd0, 1'b1, '0, 0, 0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].r, tbl[i].mode, nb, e);
      check("tbl_beats", nb, tbl[i].nbeats);
      check("tbl_err", e, tbl[i].err);
    end

    for (int n = 0; n < 40; n++) begin
      r.op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                         : 4'($urandom_range(7, 12));
      r.lmul = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                           : 3'($urandom_range(0, 2));
      r.stride  = AW'($urandom);
      r.address = AW'($urandom);
      for (int w = 0; w < DW / 32; w++)
        r.data[w*32 +: 32] = $urandom;
      r.vm   = 1'($urandom_range(0, 1));
      r.mask = {$urandom, $urandom};
      run_req(r, 2, nb, e);
      check("rnd_beats", nb, m_nbeats(r));
      check("rnd_err", e, !m_legal(r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vstore_sequencer.md
VSTORE_SEQUENCER -- requirements
Module: vstore_sequencer

Interface
REQ-001 SHALL have parameter NBANKS, default 4: number of parallel data-memory write ports (power of 2, 1..8).
REQ-002 SHALL have parameter VLEN, default 128: bits per vector register.
REQ-003 SHALL have parameter ADDR_W, default `DATAMEM_BITS (14): byte address width.
REQ-004 SHALL have parameter BANK_W, default `DATAMEM_WIDTH (32): write-port data width, >=32.
REQ-005 SHALL derive DATA_W = 4*VLEN (LMUL up to 4) and MAX_ELEMS = DATA_W/8.
REQ-006 Ports (name  direction  width  meaning); clk and nrst first. One clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  request valid.
- ready  out  1  high in IDLE only; request accepted when start && ready.
- store_op  in  4  7=vse8, 8=vse16, 9=vse32, 10=vsse8, 11=vsse16, 12=vsse32.
- lmul  in  3  000=1, 001=2, 010=4; others reserved.
- stride  in  ADDR_W  byte stride for strided ops, unsigned.
- address  in  ADDR_W  base byte address.
- data  in  DATA_W  register-group data, element i at data[i*EEW +: EEW].
- vm  in  1  1 = unmasked; 0 = use mask.
- mask  in  MAX_ELEMS  element-enable bits (v0).
- mem_addr  out  NBANKS*ADDR_W  per-port byte address.
- mem_data  out  NBANKS*BANK_W  per-port element, zero-extended.
- mem_be  out  NBANKS*(BANK_W/8)  per-port byte enables, low EEW/8 bits set.
- mem_valid  out  NBANKS  per-port write strobe.
- mem_ready  in  1  memory accepts the current beat.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done on an illegal request.

Function
REQ-007 SHALL capture store_op, lmul, stride, address, data, vm and mask into registers on acceptance; inputs are don't-care afterward.
REQ-008 SHALL derive EEW from store_op: 8, 16 or 32 bits; the element stride SHALL be EEW/8 for ops 7-9 and the captured stride for ops 10-12.
REQ-009 SHALL compute NELEM = VLEN*LMUL/EEW.
REQ-010 SHALL implement states IDLE, ISSUE, DONE: IDLE->ISSUE on acceptance; ISSUE->DONE when the last beat is accepted; DONE->IDLE unconditionally after one cycle.
REQ-011 SHALL present beat k in ISSUE, driven from registered state, starting the cycle after acceptance; beat k covers elements k*NBANKS .. k*NBANKS+NBANKS-1, with element k*NBANKS+j on port j.
REQ-012 SHALL compute each element address as address + i*element_stride, truncated modulo 2^ADDR_W (wrap-around, no error).
REQ-013 SHALL assert mem_valid[j] only if the element index is below NELEM and (vm || mask[i]); disabled ports SHALL drive addr, data and be as 0.
REQ-014 SHALL hold the beat stable while mem_ready=0 and advance on a clock edge with mem_ready=1; a beat with all mem_valid low SHALL still take one cycle and advance regardless of mem_ready.
REQ-015 SHALL pulse done in DONE only; the total number of beats SHALL be ceil(NELEM/NBANKS).
REQ-016 SHALL treat store_op outside 7..12, or reserved lmul, as illegal: accept, issue no beats, go IDLE->DONE directly, and pulse done and err together.
REQ-017 SHALL ignore start outside IDLE; start during the DONE cycle SHALL NOT be accepted.

Reset
REQ-018 On nrst=0, at any time including mid-operation, SHALL enter IDLE immediately and drive ready=1, done=0, err=0, mem_valid=0, and mem_addr/mem_data/mem_be=0; captured registers SHALL clear to 0; a partially issued request SHALL be abandoned.
REQ-019 After nrst deasserts, SHALL accept a request on the first clk edge with start=1.

Verification
REQ-020 vse32, lmul=1, address=0, data words 0x00000000..0xffffffff in 0x11111111 steps, vm=1 -> one beat: addrs 0,4,8,0xC, data 00000000/11111111/22222222/33333333, be=0xF, valid=1111; done one cycle after the beat.
REQ-021 vsse32, lmul=2, stride=8, address=0 -> beat0 addrs 0,8,0x10,0x18; beat1 addrs 0x20..0x38, data 44444444..77777777; done after 2 beats.
REQ-022 vse8, lmul=4, address=0x3FF8, mem_ready toggling 1/0 -> 16 beats; addresses wrap after 0x3FFF to 0x0000; each beat held stable through the mem_ready=0 cycles; be=0x1.
REQ-023 vse16, lmul=1, vm=0, mask=0x00F0 -> beat0 all valid=0 and advances with mem_ready=0; beat1 valid=1111; done follows.
REQ-024 store_op=3 -> no mem_valid asserted, done=err=1 for one cycle, ready returns to 1.
REQ-025 nrst pulsed low during beat 1 of REQ-021 -> outputs zero immediately, ready=1, no done pulse; a new request then completes normally.
